// File: rtl/ann_day_sequencer.sv
// Day-loop sequencer for the ANN core: per window it uploads weights, fetches the
// 4-day window and target, runs a calculation, emits the prediction and optionally trains.
module ann_day_sequencer #(
   parameter int DATA_W      = 156,
   parameter int WEIGHT_NUM  = 40,
   parameter int DAYS        = 369,
   parameter int T_AW        = 9,
   parameter int W_AW        = 14,
   parameter int CALC_CYC    = 5,
   parameter int RDY_TIMEOUT = 255
) (
   input  logic              Clk,
   input  logic              Reset_h,
   input  logic              start,
   input  logic              train_en,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [T_AW-1:0]   t_addr,
   input  logic [DATA_W-1:0] t_rdata,
   output logic [W_AW-1:0]   w_addr,
   input  logic [DATA_W-1:0] w_rdata,
   output logic              w_we,
   output logic [DATA_W-1:0] w_wdata,
   output logic [DATA_W-1:0] Temperature_in_0,
   output logic [DATA_W-1:0] Temperature_in_1,
   output logic [DATA_W-1:0] Temperature_in_2,
   output logic [DATA_W-1:0] Temperature_in_3,
   output logic [DATA_W-1:0] Target,
   output logic [DATA_W-1:0] Weight_in,
   output logic              Weight_Save_enable,
   output logic              Weight_Load_enable,
   output logic              tb_rev_ready_h,
   output logic              training_enable_h,
   input  logic [DATA_W-1:0] Data_out,
   input  logic [DATA_W-1:0] New_weight_out,
   input  logic              Ready_Signal,
   output logic              pred_valid,
   input  logic              pred_ready,
   output logic [25:0]       pred_data,
   output logic [T_AW-1:0]   pred_day,
   output logic [3:0]        dbg_state_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD_W, S_FETCH_T, S_CALC, S_WAIT_RDY,
      S_EMIT, S_TRAIN, S_READ_W, S_NEXT, S_DONE
   } state_t;

   localparam logic [15:0]     LOAD_LAST  = 16'(WEIGHT_NUM - 1);
   localparam logic [15:0]     FETCH_LAST = 16'd5;
   localparam logic [15:0]     CALC_LAST  = 16'(CALC_CYC - 1);
   localparam logic [15:0]     RDY_LAST   = 16'(RDY_TIMEOUT - 1);
   localparam logic [15:0]     READ_LAST  = 16'(WEIGHT_NUM);
   localparam logic [T_AW-1:0] LAST_DAY   = T_AW'(DAYS - 5);
   localparam logic [W_AW-1:0] BASE_STEP  = W_AW'(WEIGHT_NUM);

   state_t              state_q, state_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [T_AW-1:0]     day_q, day_d;
   logic [W_AW-1:0]     base_q, base_d;
   logic                train_q, train_d;
   logic                err_q, err_d;
   logic                save_q, save_d;
   logic [25:0]         pred_data_q, pred_data_d;
   logic [T_AW-1:0]     pred_day_q, pred_day_d;
   logic [DATA_W-1:0]   temp_q [4];
   logic [DATA_W-1:0]   temp_d [4];
   logic [DATA_W-1:0]   target_q, target_d;

   logic unused_data_hi;
   assign unused_data_hi = ^Data_out[DATA_W-1:26];

   // Next-state and datapath updates.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      day_d       = day_q;
      base_d      = base_q;
      train_d     = train_q;
      err_d       = err_q;
      save_d      = (state_q == S_LOAD_W);
      pred_data_d = pred_data_q;
      pred_day_d  = pred_day_q;
      temp_d      = temp_q;
      target_d    = target_q;
      case (state_q)
         S_IDLE: if (start) begin
            state_d = S_LOAD_W;
            cnt_d   = '0;
            day_d   = '0;
            base_d  = '0;
            train_d = train_en;
            err_d   = 1'b0;
         end
         S_LOAD_W: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == LOAD_LAST) begin
               state_d = S_FETCH_T;
               cnt_d   = '0;
            end
         end
         S_FETCH_T: begin
            // Read data lags the address by one cycle, so slot cnt-1 lands here.
            case (cnt_q)
               16'd1:   temp_d[0] = t_rdata;
               16'd2:   temp_d[1] = t_rdata;
               16'd3:   temp_d[2] = t_rdata;
               16'd4:   temp_d[3] = t_rdata;
               16'd5:   target_d  = t_rdata;
               default: ;
            endcase
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == FETCH_LAST) begin
               state_d = S_CALC;
               cnt_d   = '0;
            end
         end
         S_CALC: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == CALC_LAST) begin
               state_d = S_WAIT_RDY;
               cnt_d   = '0;
            end
         end
         S_WAIT_RDY: begin
            cnt_d = cnt_q + 16'd1;
            if (Ready_Signal) begin
               pred_data_d = Data_out[25:0];
               pred_day_d  = day_q;
               state_d     = S_EMIT;
               cnt_d       = '0;
            end else if (cnt_q == RDY_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         // pred_valid/pred_ready: a transfer happens on a cycle where both are high;
         // pred_valid, pred_data and pred_day hold steady until that cycle.
         S_EMIT: if (pred_ready) begin
            state_d = train_q ? S_TRAIN : S_NEXT;
            cnt_d   = '0;
         end
         S_TRAIN: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == 16'd1) begin
               state_d = S_READ_W;
               cnt_d   = '0;
            end
         end
         S_READ_W: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == READ_LAST) begin
               state_d = S_NEXT;
               cnt_d   = '0;
            end
         end
         S_NEXT: begin
            if (day_q == LAST_DAY) begin
               state_d = S_DONE;
               day_d   = '0;
               base_d  = '0;
            end else begin
               state_d = S_LOAD_W;
               day_d   = day_q + T_AW'(1);
               base_d  = base_q + BASE_STEP;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state; the four ANN strobes belong to disjoint states.
   always_comb begin
      busy               = (state_q != S_IDLE) && (state_q != S_DONE);
      done               = (state_q == S_DONE);
      t_addr             = '0;
      w_addr             = '0;
      w_we               = 1'b0;
      w_wdata            = '0;
      Weight_Save_enable = save_q;
      Weight_in          = save_q ? w_rdata : '0;
      Weight_Load_enable = (state_q == S_READ_W);
      tb_rev_ready_h     = (state_q == S_CALC);
      training_enable_h  = (state_q == S_TRAIN) && (cnt_q == 16'd0);
      pred_valid         = (state_q == S_EMIT);
      if (state_q == S_FETCH_T && cnt_q < FETCH_LAST)
         t_addr = day_q + T_AW'(cnt_q);
      if (state_q == S_LOAD_W)
         w_addr = base_q + W_AW'(cnt_q);
      if (state_q == S_READ_W && cnt_q != 16'd0) begin
         w_addr  = base_q + W_AW'(cnt_q - 16'd1);
         w_we    = train_q;
         w_wdata = train_q ? New_weight_out : '0;
      end
   end

   assign err              = err_q;
   assign pred_data        = pred_data_q;
   assign pred_day         = pred_day_q;
   assign Temperature_in_0 = temp_q[0];
   assign Temperature_in_1 = temp_q[1];
   assign Temperature_in_2 = temp_q[2];
   assign Temperature_in_3 = temp_q[3];
   assign Target           = target_q;
   assign dbg_state_o      = state_q;

   always_ff @(posedge Clk) begin
      if (Reset_h) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         day_q       <= '0;
         base_q      <= '0;
         train_q     <= 1'b0;
         err_q       <= 1'b0;
         save_q      <= 1'b0;
         pred_data_q <= '0;
         pred_day_q  <= '0;
         temp_q      <= '{default: '0};
         target_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         day_q       <= day_d;
         base_q      <= base_d;
         train_q     <= train_d;
         err_q       <= err_d;
         save_q      <= save_d;
         pred_data_q <= pred_data_d;
         pred_day_q  <= pred_day_d;
         temp_q      <= temp_d;
         target_q    <= target_d;
      end
   end

endmodule

// File: doc/ann_day_sequencer.md
Name: ann_day_sequencer

Overview:
- Hardware replacement for the bench-driven day loop around the ANN core. One run walks a year of daily Tmin samples in sliding 4-day windows.
- For each day it does the following, in order:
  - uploads that day's 40-weight set;
  - presents the window and triggers calculation;
  - emits the prediction;
  - optionally trains against day+4;
  - writes the updated weights back to the same weight bank slot.
- Sits between the sample/weight RAMs and the ANN core.

Parameters:
- DATA_W, 156, width of temperature/weight/target words (INPUT_SIZE*12).
- WEIGHT_NUM, 40, weights per day set (INPUT_NUM*NEURON_NUM+NEURON_NUM).
- DAYS, 369, samples per year (ONE_YEAR); windows processed = DAYS-4.
- T_AW, 9, sample RAM address width.
- W_AW, 14, weight RAM address width (must hold (DAYS-4)*WEIGHT_NUM).
- CALC_CYC, 5, cycles tb_rev_ready_h is held high.
- RDY_TIMEOUT, 255, max cycles waiting for Ready_Signal.

Ports:
- Clk  in  1  clock
- Reset_h  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, begins a year run (ignored unless IDLE)
- train_en  in  1  sampled at start; 1 = train and write back weights
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse at end of run
- err  out  1  sticky Ready_Signal timeout flag; cleared by reset or accepted start
- t_addr  out  T_AW  sample RAM read address
- t_rdata  in  DATA_W  sample RAM data, valid 1 cycle after t_addr
- w_addr  out  W_AW  weight RAM address
- w_rdata  in  DATA_W  weight RAM read data, 1-cycle latency
- w_we  out  1  weight RAM write enable
- w_wdata  out  DATA_W  weight RAM write data
- Temperature_in_0..3  out  DATA_W each  ANN window inputs (oldest = _0)
- Target  out  DATA_W  ANN target (sample day+4)
- Weight_in  out  DATA_W  ANN weight bus
- Weight_Save_enable  out  1  ANN weight upload strobe
- Weight_Load_enable  out  1  ANN weight readback strobe
- tb_rev_ready_h  out  1  ANN calculate request
- training_enable_h  out  1  ANN training pulse
- Data_out  in  DATA_W  ANN result
- New_weight_out  in  DATA_W  ANN updated weight, one per cycle while Weight_Load_enable
- Ready_Signal  in  1  ANN result-valid
- pred_valid  out  1  prediction available
- pred_ready  in  1  consumer accepts prediction
- pred_data  out  26  Data_out[25:0] captured at Ready_Signal
- pred_day  out  T_AW  window index of pred_data

Behaviour:
- Reset (sync, any state, mid-run included):
  - state=IDLE; every output = 0, including Temperature_in_*, Target, Weight_in and pred_data;
  - day counter and weight base register = 0.
- IDLE -> LOAD_W on start (latches train_en, clears err); busy=1 next cycle.
- LOAD_W: issues w_addr = base+k for k=0..WEIGHT_NUM-1, one per cycle.
  - One cycle later: Weight_in = w_rdata, Weight_Save_enable=1.
  - Exactly WEIGHT_NUM consecutive strobe cycles, then 0.
- FETCH_T: reads t_addr = day..day+4 on 5 consecutive cycles.
  - Registers results into Temperature_in_0..3 and Target.
  - Inputs and Target stay stable until the next FETCH_T.
- CALC: tb_rev_ready_h=1 for CALC_CYC cycles, then WAIT_RDY.
- WAIT_RDY: on the first cycle with Ready_Signal=1, capture Data_out[25:0] into pred_data and pred_day=day, then go to EMIT.
  - If RDY_TIMEOUT cycles elapse: err=1, go to IDLE (busy=0, no done pulse).
- EMIT: pred_valid=1 held with data stable until pred_valid&&pred_ready.
  - Then go to TRAIN if train_en latched, else NEXT.
- TRAIN: training_enable_h=1 for exactly 1 cycle, then 1 idle cycle, then READ_W.
- READ_W: Weight_Load_enable=1 for WEIGHT_NUM+1 cycles; first cycle is settle.
  - Cycles 2..WEIGHT_NUM+1: w_we=1, w_addr=base+j, w_wdata=New_weight_out, j=0..39.
- NEXT: day+=1, base+=WEIGHT_NUM (adder, no multiplier).
  - If day==DAYS-5 before increment: go to DONE. Else go to LOAD_W.
- DONE: done=1 for one cycle, busy=0, go to IDLE. Counters reset to 0 for the next run.
- start while busy: ignored.
- Ready_Signal asserted outside WAIT_RDY: ignored.
- Strobe exclusivity: at most one of Weight_Save_enable, Weight_Load_enable, tb_rev_ready_h, training_enable_h is high in any cycle.
- w_we=0 whenever train_en was latched 0: weight bank is read-only in inference runs.

Test Plan:
- Reset/idle: hold Reset_h 3 cycles mid-LOAD_W -> all outputs 0 next cycle, state IDLE; pulse start -> busy=1 next cycle, first w_addr=0.
- Weight upload: bank day0 = 0x1..0x28, start with train_en=0 -> Weight_Save_enable high exactly 40 cycles, Weight_in sequence 0x1..0x28 in order.
- Window/target: samples s[i]=i+0x100 -> day 3 presents Temperature_in_0..3=0x103..0x106, Target=0x107, pred_day=3.
- Backpressure: hold pred_ready=0 for 10 cycles after pred_valid -> pred_data stable, no state advance; release -> exactly one transfer.
- Training write-back: train_en=1, model returns New_weight_out=0xA00+j -> w_we pulses 40 cycles, day1 writes addr 40..79 with 0xA00..0xA27; training_enable_h one cycle per day.
- Timeout and end: model never raises Ready_Signal -> err=1 after 255 wait cycles, busy=0, no done. Full run DAYS=9 -> 5 predictions (pred_day 0..4), single done pulse.
